pcie_app_msg_framer: RTL and testbench

//  Per-application framer on the app side of the virtualized PCIe interface, one instance per app slot.
//  RX: collects PCIEPacket beats up to the 'last' beat into a message buffer.
//    It then presents the whole message to app logic with valid/ready.
//  TX: segments an app message into PCIEPacket beats, advancing one beat per grant.

---
 rtl/pcie_app_msg_framer_pkg.sv | 29 ++
 rtl/pcie_msg_segmenter.sv | 100 ++++++++++
 rtl/pcie_app_msg_framer.sv | 170 +++++++++++++++++
 tb/tb_pcie_app_msg_framer.sv | 401 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pcie_app_msg_framer_pkg.sv
// Shared types for the per-app PCIe message framer: the shell beat format,
// the message metadata record and the framer FSM state encodings.
package pcie_app_msg_framer_pkg;

  localparam int unsigned PCIE_DATA_WIDTH       = 128;
  localparam int unsigned PCIE_SLOT_WIDTH       = 4;
  localparam int unsigned PCIE_PAD_WIDTH        = 4;
  localparam int unsigned PCIE_FRAMER_MAX_BEATS = 4;
  // Wide enough for any practical MAX_BEATS; narrower counts are zero-extended.
  localparam int unsigned PCIE_MSG_BEATS_WIDTH  = 8;

  typedef struct packed {
    logic                       valid;
    logic [PCIE_DATA_WIDTH-1:0] data;
    logic [PCIE_SLOT_WIDTH-1:0] slot;
    logic [PCIE_PAD_WIDTH-1:0]  pad;
    logic                       last;
  } PCIEPacket;

  typedef struct packed {
    logic [PCIE_SLOT_WIDTH-1:0]      slot;
    logic [PCIE_PAD_WIDTH-1:0]       pad;
    logic [PCIE_MSG_BEATS_WIDTH-1:0] beats;
  } PCIEMsgMeta;

  typedef enum logic {RxCollect, RxHold} rx_state_e;
  typedef enum logic {TxIdle, TxSend} tx_state_e;

endpackage

// File: rtl/pcie_msg_segmenter.sv
// TX segmenter: latches one app message and emits it as PCIEPacket beats,
// advancing one beat per grant. Beats are held stable until granted.
module pcie_msg_segmenter
  import pcie_app_msg_framer_pkg::*;
#(
  parameter int unsigned MAX_BEATS = PCIE_FRAMER_MAX_BEATS
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 msg_valid,
  output logic                                 msg_ready,
  input  logic [MAX_BEATS*PCIE_DATA_WIDTH-1:0] msg_data,
  input  PCIEMsgMeta                           msg_meta,
  input  logic                                 grant,
  output PCIEPacket                            pkt
);

  localparam int unsigned BW = PCIE_MSG_BEATS_WIDTH;

  tx_state_e                                 state_q, state_d;
  logic [MAX_BEATS-1:0][PCIE_DATA_WIDTH-1:0] data_q, data_d;
  PCIEMsgMeta                                meta_q, meta_d;
  logic [BW-1:0]                             idx_q, idx_d;
  logic [BW-1:0]                             beats_in;
  logic [PCIE_DATA_WIDTH-1:0]                cur_beat;
  logic                                      is_last;

  // Clamp the requested length into 1..MAX_BEATS (0 means a single beat).
  always_comb begin
    beats_in = msg_meta.beats;
    if (beats_in == '0) begin
      beats_in = BW'(1);
    end else if (beats_in > BW'(MAX_BEATS)) begin
      beats_in = BW'(MAX_BEATS);
    end
  end

  // Select the beat at the current index.
  always_comb begin
    cur_beat = '0;
    for (int unsigned i = 0; i < MAX_BEATS; i++) begin
      if (idx_q == BW'(i)) cur_beat = data_q[i];
    end
  end

  assign is_last = (idx_q == meta_q.beats - BW'(1));

  // Next-state and beat output decode.
  always_comb begin
    state_d   = state_q;
    data_d    = data_q;
    meta_d    = meta_q;
    idx_d     = idx_q;
    msg_ready = 1'b0;
    pkt       = '0;
    case (state_q)
      TxIdle: begin
        msg_ready = 1'b1;
        if (msg_valid) begin
          data_d       = msg_data;
          meta_d       = msg_meta;
          meta_d.beats = beats_in;
          idx_d        = '0;
          state_d      = TxSend;
        end
      end
      TxSend: begin
        pkt.valid = 1'b1;
        pkt.data  = cur_beat;
        pkt.slot  = meta_q.slot;
        pkt.last  = is_last;
        pkt.pad   = is_last ? meta_q.pad : '0;
        if (grant) begin
          if (is_last) begin
            state_d = TxIdle;
          end else begin
            idx_d = idx_q + BW'(1);
          end
        end
      end
      default: state_d = TxIdle;
    endcase
  end

  // State register; reset drops any message in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= TxIdle;
      data_q  <= '0;
      meta_q  <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      meta_q  <= meta_d;
      idx_q   <= idx_d;
    end
  end

endmodule

// File: rtl/pcie_app_msg_framer.sv
// Per-app PCIe message framer. RX assembles inbound beats into a message
// buffer presented with valid/ready; TX segments app messages into beats.
// Optional statistics counters are built when PCIE_FRAMER_STATS_EN is defined.
module pcie_app_msg_framer
  import pcie_app_msg_framer_pkg::*;
#(
  parameter int unsigned  MAX_BEATS = PCIE_FRAMER_MAX_BEATS,
  localparam int unsigned CNT_W     = $clog2(MAX_BEATS + 1)
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  PCIEPacket                            pcie_packet_in,
  output logic                                 pcie_full_out,
  output PCIEPacket                            pcie_packet_out,
  input  logic                                 pcie_grant_in,
  output logic                                 rx_msg_valid,
  input  logic                                 rx_msg_ready,
  output logic [MAX_BEATS*PCIE_DATA_WIDTH-1:0] rx_msg_data,
  output logic [CNT_W-1:0]                     rx_msg_beats,
  output logic [PCIE_SLOT_WIDTH-1:0]           rx_msg_slot,
  output logic [PCIE_PAD_WIDTH-1:0]            rx_msg_pad,
  input  logic                                 tx_msg_valid,
  output logic                                 tx_msg_ready,
  input  logic [MAX_BEATS*PCIE_DATA_WIDTH-1:0] tx_msg_data,
  input  logic [CNT_W-1:0]                     tx_msg_beats,
  input  logic [PCIE_SLOT_WIDTH-1:0]           tx_msg_slot,
  input  logic [PCIE_PAD_WIDTH-1:0]            tx_msg_pad,
  output logic                                 err_overflow,
  output logic                                 err_slot,
  output logic [31:0]                          stat_rx_msgs,
  output logic [31:0]                          stat_tx_msgs
);

  rx_state_e                                 rx_state_q, rx_state_d;
  logic [CNT_W-1:0]                          count_q, count_d;
  logic [MAX_BEATS-1:0][PCIE_DATA_WIDTH-1:0] buf_q, buf_d;
  logic [PCIE_SLOT_WIDTH-1:0]                slot_q, slot_d;
  logic [PCIE_PAD_WIDTH-1:0]                 pad_q, pad_d;
  logic                                      err_overflow_q, err_overflow_d;
  logic                                      err_slot_q, err_slot_d;
  logic                                      rx_accept;
  logic                                      rx_handshake;
  PCIEMsgMeta                                tx_meta;

  assign rx_accept    = pcie_packet_in.valid && (rx_state_q == RxCollect);
  assign rx_handshake = (rx_state_q == RxHold) && rx_msg_ready;

  // RX collect/hold next-state: store beats, flag overflow and slot changes.
  always_comb begin
    rx_state_d     = rx_state_q;
    count_d        = count_q;
    buf_d          = buf_q;
    slot_d         = slot_q;
    pad_d          = pad_q;
    err_overflow_d = err_overflow_q;
    err_slot_d     = err_slot_q;
    case (rx_state_q)
      RxCollect: begin
        if (rx_accept) begin
          if (count_q == '0) begin
            slot_d = pcie_packet_in.slot;
          end else if (pcie_packet_in.slot != slot_q) begin
            err_slot_d = 1'b1;
          end
          if (count_q == CNT_W'(MAX_BEATS)) begin
            err_overflow_d = 1'b1;
          end else begin
            for (int unsigned i = 0; i < MAX_BEATS; i++) begin
              if (count_q == CNT_W'(i)) buf_d[i] = pcie_packet_in.data;
            end
            count_d = count_q + CNT_W'(1);
          end
          // A dropped last beat still closes the message.
          if (pcie_packet_in.last) begin
            pad_d      = pcie_packet_in.pad;
            rx_state_d = RxHold;
          end
        end
      end
      RxHold: begin
        if (rx_handshake) begin
          buf_d      = '0;
          count_d    = '0;
          slot_d     = '0;
          pad_d      = '0;
          rx_state_d = RxCollect;
        end
      end
      default: rx_state_d = RxCollect;
    endcase
  end

  // RX state, buffer and sticky error registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_state_q     <= RxCollect;
      count_q        <= '0;
      buf_q          <= '0;
      slot_q         <= '0;
      pad_q          <= '0;
      err_overflow_q <= 1'b0;
      err_slot_q     <= 1'b0;
    end else begin
      rx_state_q     <= rx_state_d;
      count_q        <= count_d;
      buf_q          <= buf_d;
      slot_q         <= slot_d;
      pad_q          <= pad_d;
      err_overflow_q <= err_overflow_d;
      err_slot_q     <= err_slot_d;
    end
  end

  // Backpressure is a pure state decode so there is no input-to-full path.
  assign pcie_full_out = (rx_state_q == RxHold);
  assign rx_msg_valid  = (rx_state_q == RxHold);
  assign rx_msg_data   = buf_q;
  assign rx_msg_beats  = count_q;
  assign rx_msg_slot   = slot_q;
  assign rx_msg_pad    = pad_q;
  assign err_overflow  = err_overflow_q;
  assign err_slot      = err_slot_q;

  // Pack the app TX request into the segmenter metadata record.
  always_comb begin
    tx_meta       = '0;
    tx_meta.slot  = tx_msg_slot;
    tx_meta.pad   = tx_msg_pad;
    tx_meta.beats = PCIE_MSG_BEATS_WIDTH'(tx_msg_beats);
  end

  pcie_msg_segmenter #(
    .MAX_BEATS (MAX_BEATS)
  ) u_segmenter (
    .clk       (clk),
    .rst_n     (rst_n),
    .msg_valid (tx_msg_valid),
    .msg_ready (tx_msg_ready),
    .msg_data  (tx_msg_data),
    .msg_meta  (tx_meta),
    .grant     (pcie_grant_in),
    .pkt       (pcie_packet_out)
  );

`ifdef PCIE_FRAMER_STATS_EN
  logic [31:0] stat_rx_q;
  logic [31:0] stat_tx_q;
  logic        tx_done;

  assign tx_done = pcie_packet_out.valid && pcie_packet_out.last && pcie_grant_in;

  // Saturating message counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_rx_q <= '0;
      stat_tx_q <= '0;
    end else begin
      if (rx_handshake && (stat_rx_q != '1)) stat_rx_q <= stat_rx_q + 32'd1;
      if (tx_done && (stat_tx_q != '1)) stat_tx_q <= stat_tx_q + 32'd1;
    end
  end

  assign stat_rx_msgs = stat_rx_q;
  assign stat_tx_msgs = stat_tx_q;
`else
  assign stat_rx_msgs = '0;
  assign stat_tx_msgs = '0;
`endif

endmodule

// File: tb/tb_pcie_app_msg_framer.sv
// Self-checking bench for pcie_app_msg_framer (MAX_BEATS=4): table-driven RX/TX
// message vectors with scoreboard queues, plus hand-written hold, reset and
// statistics sequences.
module tb_pcie_app_msg_framer;
  import pcie_app_msg_framer_pkg::*;

  localparam int unsigned MB = 4;
  localparam int unsigned CW = 3;
  localparam int unsigned DW = PCIE_DATA_WIDTH;

  logic              clk = 1'b0;
  logic              rst_n;
  PCIEPacket         pkt_in;
  PCIEPacket         pkt_out;
  logic              full;
  logic              grant;
  logic              rx_valid;
  logic              rx_ready;
  logic [MB*DW-1:0]  rx_data;
  logic [CW-1:0]     rx_beats;
  logic [3:0]        rx_slot;
  logic [3:0]        rx_pad;
  logic              tx_valid;
  logic              tx_ready;
  logic [MB*DW-1:0]  tx_data;
  logic [CW-1:0]     tx_beats;
  logic [3:0]        tx_slot;
  logic [3:0]        tx_pad;
  logic              err_ovf;
  logic              err_slt;
  logic [31:0]       stat_rx;
  logic [31:0]       stat_tx;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [MB*DW-1:0] data;
    logic [CW-1:0]    beats;
    logic [3:0]       slot;
    logic [3:0]       pad;
  } rx_exp_t;

  typedef struct {
    logic [DW-1:0] data;
    logic [3:0]    slot;
    logic [3:0]    pad;
    logic          last;
  } tx_exp_t;

  typedef struct {
    int         n;
    logic [3:0] slot;
    logic [3:0] pad;
    int         flip;
    logic       exp_ovf;
    logic       exp_serr;
  } rx_vec_t;

  typedef struct {
    int         beats;
    logic [3:0] slot;
    logic [3:0] pad;
    int         d0;
    int         dn;
  } tx_vec_t;

  rx_exp_t rxq[$];
  tx_exp_t txq[$];
  rx_exp_t rx_e;
  tx_exp_t tx_e;
  rx_vec_t rx_tab[6];
  tx_vec_t tx_tab[5];

  pcie_app_msg_framer #(
    .MAX_BEATS (MB)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .pcie_packet_in  (pkt_in),
    .pcie_full_out   (full),
    .pcie_packet_out (pkt_out),
    .pcie_grant_in   (grant),
    .rx_msg_valid    (rx_valid),
    .rx_msg_ready    (rx_ready),
    .rx_msg_data     (rx_data),
    .rx_msg_beats    (rx_beats),
    .rx_msg_slot     (rx_slot),
    .rx_msg_pad      (rx_pad),
    .tx_msg_valid    (tx_valid),
    .tx_msg_ready    (tx_ready),
    .tx_msg_data     (tx_data),
    .tx_msg_beats    (tx_beats),
    .tx_msg_slot     (tx_slot),
    .tx_msg_pad      (tx_pad),
    .err_overflow    (err_ovf),
    .err_slot        (err_slt),
    .stat_rx_msgs    (stat_rx),
    .stat_tx_msgs    (stat_tx)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic timeout_fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s timed out", name);
  endtask

  function automatic logic [DW-1:0] beat_val(input logic [31:0] seed, input int i);
    return {seed, 32'(i), ~seed, 32'h0000_00B0 + 32'(i)};
  endfunction

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_tx_ready"}, tx_ready, 1);
    chk({tag, "_full"}, full, 0);
    chk({tag, "_rx_valid"}, rx_valid, 0);
    chk({tag, "_pkt_out"}, pkt_out, 0);
    chk({tag, "_rx_data"}, rx_data, 0);
    chk({tag, "_rx_beats"}, rx_beats, 0);
    chk({tag, "_rx_slot_pad"}, {rx_slot, rx_pad}, 0);
    chk({tag, "_errs"}, {err_ovf, err_slt}, 0);
    chk({tag, "_stats"}, {stat_rx, stat_tx}, 0);
  endtask

  // Drive one inbound message; flip>=0 corrupts the slot of that beat.
  task automatic rx_send(input int n, input logic [3:0] slot, input logic [3:0] pad,
                         input int flip, input logic [31:0] seed);
    rx_exp_t e;
    e.data  = '0;
    e.beats = (n > MB) ? CW'(MB) : CW'(n);
    e.slot  = slot;
    e.pad   = pad;
    for (int i = 0; i < n && i < MB; i++) e.data[i*DW +: DW] = beat_val(seed, i);
    rxq.push_back(e);
    for (int i = 0; i < n; i++) begin
      int t;
      t = 0;
      while (full && t < 40) begin
        @(posedge clk);
        #1;
        t++;
      end
      if (t >= 40) timeout_fail("rx_full_wait");
      pkt_in.valid = 1'b1;
      pkt_in.data  = beat_val(seed, i);
      pkt_in.slot  = (i == flip) ? (slot ^ 4'h1) : slot;
      pkt_in.last  = (i == n - 1);
      pkt_in.pad   = (i == n - 1) ? pad : 4'h0;
      @(posedge clk);
      #1;
    end
    pkt_in = '0;
  endtask

  // Offer one app message, then grant beat 0 after d0 cycles and later beats after dn.
  task automatic tx_send(input int bf, input logic [3:0] slot, input logic [3:0] pad,
                         input logic [31:0] seed, input int d0, input int dn);
    tx_exp_t e;
    int      n;
    int      t;
    n = (bf == 0) ? 1 : bf;
    tx_data = '0;
    for (int i = 0; i < n; i++) begin
      e.data = beat_val(seed, i);
      e.slot = slot;
      e.last = (i == n - 1);
      e.pad  = (i == n - 1) ? pad : 4'h0;
      txq.push_back(e);
      tx_data[i*DW +: DW] = beat_val(seed, i);
    end
    tx_valid = 1'b1;
    tx_beats = CW'(bf);
    tx_slot  = slot;
    tx_pad   = pad;
    t = 0;
    while (!tx_ready && t < 40) begin
      @(posedge clk);
      #1;
      t++;
    end
    if (t >= 40) timeout_fail("tx_ready_wait");
    @(posedge clk);
    #1;
    tx_valid = 1'b0;
    for (int b = 0; b < n; b++) begin
      int d;
      d = (b == 0) ? d0 : dn;
      for (int k = 0; k < d; k++) begin
        @(negedge clk);
        chk("tx_hold_valid", pkt_out.valid, 1);
        if (txq.size() > 0) chk("tx_hold_data", pkt_out.data, txq[0].data);
        chk("tx_busy_ready", tx_ready, 0);
        @(posedge clk);
        #1;
      end
      grant = 1'b1;
      @(posedge clk);
      #1;
      grant = 1'b0;
    end
  endtask

  // RX scoreboard: compare the presented message on each handshake.
  always @(negedge clk) begin
    if (rst_n && rx_valid && rx_ready) begin
      if (rxq.size() == 0) begin
        timeout_fail("rx_unexpected_msg");
      end else begin
        rx_e = rxq.pop_front();
        chk("rx_data", rx_data, rx_e.data);
        chk("rx_beats", rx_beats, rx_e.beats);
        chk("rx_slot", rx_slot, rx_e.slot);
        chk("rx_pad", rx_pad, rx_e.pad);
      end
    end
  end

  // TX scoreboard: compare each granted beat.
  always @(negedge clk) begin
    if (rst_n && pkt_out.valid && grant) begin
      if (txq.size() == 0) begin
        timeout_fail("tx_unexpected_beat");
      end else begin
        tx_e = txq.pop_front();
        chk("tx_data", pkt_out.data, tx_e.data);
        chk("tx_slot", pkt_out.slot, tx_e.slot);
        chk("tx_pad", pkt_out.pad, tx_e.pad);
        chk("tx_last", pkt_out.last, tx_e.last);
      end
    end
  end

  initial begin
    int exp_stat_rx;
    int exp_stat_tx;
    rx_tab[0] = '{3, 4'h5, 4'h3, -1, 1'b0, 1'b0};
    rx_tab[1] = '{1, 4'h2, 4'h0, -1, 1'b0, 1'b0};
    rx_tab[2] = '{4, 4'h9, 4'hF, -1, 1'b0, 1'b0};
    rx_tab[3] = '{2, 4'h1, 4'h7,  1, 1'b0, 1'b1};
    rx_tab[4] = '{5, 4'h5, 4'h4, -1, 1'b1, 1'b1};
    rx_tab[5] = '{2, 4'h3, 4'h1, -1, 1'b1, 1'b1};
    tx_tab[0] = '{2, 4'h7, 4'h2, 0, 2};
    tx_tab[1] = '{4, 4'h3, 4'h9, 0, 0};
    tx_tab[2] = '{1, 4'h1, 4'h5, 1, 0};
    tx_tab[3] = '{0, 4'h6, 4'h4, 0, 0};
    tx_tab[4] = '{3, 4'h2, 4'h1, 2, 1};

    rst_n    = 1'b0;
    pkt_in   = '0;
    grant    = 1'b0;
    rx_ready = 1'b1;
    tx_valid = 1'b0;
    tx_data  = '0;
    tx_beats = '0;
    tx_slot  = '0;
    tx_pad   = '0;
    #2;
    check_reset_outputs("reset");
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;

    // RX hold: app stalls for 10 cycles while a stray beat is offered.
    rx_ready = 1'b0;
    rx_send(2, 4'hA, 4'h6, -1, 32'h0000_1000);
    pkt_in.valid = 1'b1;
    pkt_in.data  = beat_val(32'hDEAD_0000, 0);
    pkt_in.slot  = 4'hA;
    pkt_in.last  = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      chk("hold_full", full, 1);
      chk("hold_valid", rx_valid, 1);
      chk("hold_beats", rx_beats, 2);
      @(posedge clk);
      #1;
    end
    pkt_in   = '0;
    rx_ready = 1'b1;
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("hold_release_full", full, 0);

    // RX table: latency, contents via scoreboard, sticky error flags.
    for (int v = 0; v < 6; v++) begin
      rx_send(rx_tab[v].n, rx_tab[v].slot, rx_tab[v].pad, rx_tab[v].flip, 32'h0000_2000 + 32'(v));
      @(negedge clk);
      chk("rx_latency_valid", rx_valid, 1);
      chk("rx_err_overflow", err_ovf, rx_tab[v].exp_ovf);
      chk("rx_err_slot", err_slt, rx_tab[v].exp_serr);
    end

    // TX table: hold/grant timing, zero-length request, return to ready.
    for (int v = 0; v < 5; v++) begin
      tx_send(tx_tab[v].beats, tx_tab[v].slot, tx_tab[v].pad, 32'h0000_3000 + 32'(v),
              tx_tab[v].d0, tx_tab[v].dn);
      @(negedge clk);
      chk("tx_ready_after", tx_ready, 1);
      chk("tx_idle_valid", pkt_out.valid, 0);
    end

    // Grant while idle must be ignored.
    @(posedge clk);
    #1;
    grant = 1'b1;
    @(posedge clk);
    #1;
    grant = 1'b0;
    @(negedge clk);
    chk("stray_grant_ready", tx_ready, 1);
    chk("stray_grant_valid", pkt_out.valid, 0);
    chk("overflow_sticky", err_ovf, 1);

    // Reset mid-message in both directions.
    tx_e.data = beat_val(32'h0000_4000, 0);
    tx_e.slot = 4'hC;
    tx_e.pad  = 4'h0;
    tx_e.last = 1'b0;
    txq.push_back(tx_e);
    tx_data          = '0;
    tx_data[0 +: DW] = beat_val(32'h0000_4000, 0);
    tx_data[DW +: DW] = beat_val(32'h0000_4000, 1);
    tx_beats = CW'(2);
    tx_slot  = 4'hC;
    tx_pad   = 4'h8;
    tx_valid = 1'b1;
    @(posedge clk);
    #1;
    tx_valid = 1'b0;
    grant    = 1'b1;
    @(posedge clk);
    #1;
    grant = 1'b0;
    for (int i = 0; i < 2; i++) begin
      pkt_in.valid = 1'b1;
      pkt_in.data  = beat_val(32'h0000_5000, i);
      pkt_in.slot  = 4'hD;
      pkt_in.last  = 1'b0;
      @(posedge clk);
      #1;
    end
    pkt_in = '0;
    @(negedge clk);
    chk("pre_reset_tx_pending", pkt_out.valid, 1);
    chk("pre_reset_rx_beats", rx_beats, 2);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #2;
    check_reset_outputs("midreset");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_reset_no_beat", pkt_out.valid, 0);
    chk("post_reset_rx_beats", rx_beats, 0);

    // Post-reset traffic with simultaneous RX and TX; statistics.
    fork
      rx_send(3, 4'h4, 4'h2, -1, 32'h0000_6000);
      tx_send(2, 4'h8, 4'h3, 32'h0000_6100, 0, 1);
    join
    rx_send(1, 4'h4, 4'h5, -1, 32'h0000_6200);
    rx_send(4, 4'h6, 4'h1, -1, 32'h0000_6300);
    tx_send(3, 4'h9, 4'h7, 32'h0000_6400, 1, 0);
    repeat (3) @(posedge clk);
    @(negedge clk);
`ifdef PCIE_FRAMER_STATS_EN
    exp_stat_rx = 3;
    exp_stat_tx = 2;
`else
    exp_stat_rx = 0;
    exp_stat_tx = 0;
`endif
    chk("stat_rx_msgs", stat_rx, 32'(exp_stat_rx));
    chk("stat_tx_msgs", stat_tx, 32'(exp_stat_tx));
    chk("post_reset_errs", {err_ovf, err_slt}, 0);
    chk("rx_queue_drained", 32'(rxq.size()), 0);
    chk("tx_queue_drained", 32'(txq.size()), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
